// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: types and constants shared by the data RAM arbiter and the core.
//   owner_e     - identifies which requester owns the RAM port
//   RAM_ADDR_W  - data RAM address width (128 words)
//   RAM_DATA_W  - data RAM word width
//   CNT_W       - width of the burst counter
//   sat_inc()   - increment that saturates at a limit
package ram_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int RAM_ADDR_W = 7;
  localparam int RAM_DATA_W = 8;
  localparam int CNT_W      = 4;

  // Increment v by one but never beyond lim.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// data_ram_arbiter_if: one requester's access channel to the shared data RAM.
//   req/we/addr/wdata - request driven by the requester (master)
//   gnt               - access accepted this cycle (combinational)
//   rvalid/rdata      - read return, exactly one cycle after a granted read
interface data_ram_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single-port data RAM between the CPU execute
// stage and the debug/DMA port. Sticky grant with a burst limit; read data is
// routed back to whichever requester issued the read one cycle earlier.
//   clk, rst    - clock, synchronous active-high reset
//   cpu_if      - CPU request channel (slave side)
//   dbg_if      - debug/DMA request channel (slave side)
//   ram_addr_o  - RAM address
//   ram_data_o  - RAM write data
//   ram_en_o    - RAM write enable
//   ram_q_i     - RAM registered read data
module data_ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = RAM_ADDR_W,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_arbiter_if.slave cpu_if,
  data_ram_arbiter_if.slave dbg_if,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_en_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);

  owner_e           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rp_cpu_q, rp_cpu_d;
  logic             rp_dbg_q, rp_dbg_d;

  logic             cpu_gnt;
  logic             dbg_gnt;
  owner_e           winner;

  // Arbiter state and read-pending flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= OWN_CPU;
      cnt_q    <= 4'd0;
      rp_cpu_q <= 1'b0;
      rp_dbg_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      rp_cpu_q <= rp_cpu_d;
      rp_dbg_q <= rp_dbg_d;
    end
  end

  // Grant decision, RAM port muxing and next arbiter state.
  always_comb begin
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    winner     = last_q;
    ram_addr_o = {ADDR_W{1'b0}};
    ram_data_o = {DATA_W{1'b0}};
    ram_en_o   = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;

    if (cpu_if.req && dbg_if.req) begin
      // Stay with the current owner until it has used its burst allowance.
      if (cnt_q < MAX_BURST_C) begin
        winner = last_q;
      end else begin
        winner = (last_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
      end
      cpu_gnt = (winner == OWN_CPU);
      dbg_gnt = (winner == OWN_DBG);
    end else if (cpu_if.req) begin
      cpu_gnt = 1'b1;
    end else if (dbg_if.req) begin
      dbg_gnt = 1'b1;
    end else begin
      cpu_gnt = 1'b0;
      dbg_gnt = 1'b0;
    end

    if (cpu_gnt) begin
      ram_addr_o = cpu_if.addr;
      ram_data_o = cpu_if.wdata;
      ram_en_o   = cpu_if.we;
    end else if (dbg_gnt) begin
      ram_addr_o = dbg_if.addr;
      ram_data_o = dbg_if.wdata;
      ram_en_o   = dbg_if.we;
    end else begin
      ram_addr_o = {ADDR_W{1'b0}};
      ram_data_o = {DATA_W{1'b0}};
      ram_en_o   = 1'b0;
    end

    if (cpu_gnt || dbg_gnt) begin
      if ((cpu_gnt ? OWN_CPU : OWN_DBG) == last_q) begin
        cnt_d = sat_inc(cnt_q, MAX_BURST_C);
      end else begin
        last_d = cpu_gnt ? OWN_CPU : OWN_DBG;
        cnt_d  = 4'd1;
      end
    end else begin
      // An idle cycle ends the burst; ownership is remembered.
      cnt_d = 4'd0;
    end

    rp_cpu_d = cpu_gnt && !cpu_if.we;
    rp_dbg_d = dbg_gnt && !dbg_if.we;
  end

  assign cpu_if.gnt    = cpu_gnt;
  assign dbg_if.gnt    = dbg_gnt;
  assign cpu_if.rvalid = rp_cpu_q;
  assign dbg_if.rvalid = rp_dbg_q;
  // Read data is gated so an idle port never sees the other port's data.
  assign cpu_if.rdata  = rp_cpu_q ? ram_q_i : {DATA_W{1'b0}};
  assign dbg_if.rdata  = rp_dbg_q ? ram_q_i : {DATA_W{1'b0}};

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port 128x8 data RAM between the CPU core's execute stage and a debug/DMA port, so that a host can read and write file registers while the program runs.
- Sits between both requesters and the RAM macro, replacing the core's direct drive of the RAM address, data and write-enable.
- Uses a sticky grant with a burst limit, plus read-return tracking per requester.

Parameters:
- ADDR_W, 7, RAM address width (128 words).
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU requests an access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same widths and meanings for the debug port.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_data  out  DATA_W  to RAM data.
- ram_en  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data; registered, valid 1 cycle after the address is presented.

Behaviour:
- Transfer rule: a transfer occurs in any cycle with req && gnt. Grants are combinational from the current req inputs and the registered arbiter state. At most one gnt is high per cycle.
- Grant is independent of we and addr.
- State registers:
  - last: owner_e, the most recently granted requester.
  - cnt: 4 bits, consecutive grants to last, saturating at MAX_BURST.
  - rp_cpu, rp_dbg: 1-cycle read-pending flags.
- Reset values: last = OWN_CPU, cnt = 0, rp_cpu = rp_dbg = 0.
  - Outputs at reset: cpu_gnt = dbg_gnt = 0 unless req is asserted in the following cycle; all rvalid = 0; ram_en = 0.
- Arbitration, one requester asserting req: that requester is granted.
- Arbitration, both asserting req:
  - If cnt < MAX_BURST, grant last.
  - Otherwise grant the other requester.
  - First tie after reset goes to the CPU.
- State update, grant to g:
  - g == last: cnt <= min(cnt+1, MAX_BURST).
  - g != last: last <= g, cnt <= 1.
- State update, no req asserted: cnt <= 0, last unchanged.
- Starvation bound: neither requester waits more than MAX_BURST cycles while asserting req.
- RAM drive:
  - Granted requester: ram_addr = its addr, ram_data = its wdata, ram_en = its we.
  - No grant: ram_addr = 0, ram_data = 0, ram_en = 0.
- Write: the RAM captures the write at the grant cycle's clock edge. Nothing is returned and no rvalid is asserted.
- Read: on a granted read, set rp_x for the next cycle.
  - x_rvalid = rp_x.
  - x_rdata = ram_q while rp_x is high, else 0. Latency is exactly 1 cycle.
- Back-to-back reads by either requester are allowed every cycle, including alternating owners. Each rvalid pulse corresponds to exactly one granted read.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM write-first), whoever the requesters are.
- Requester obligations:
  - Hold req, we, addr and wdata stable until gnt.
  - An ungranted request has no effect on the RAM.
  - Dropping req before gnt is legal: the request is withdrawn with no side effect.
- Reset mid-operation: rp flags clear, so no rvalid is issued in the cycle after rst even if a read was granted in the reset cycle. A grant combinationally present in the reset cycle still drives ram_en; requesters must not assert req during rst.
- Width: all data paths are pass-through with no arithmetic except the cnt saturation.

Decomposition:
- Package ram_arb_pkg:
  - typedef enum logic {OWN_CPU, OWN_DBG} owner_e.
  - Localparam RAM_ADDR_W = 7, RAM_DATA_W = 8, shared with the core.
- No sub-module: the block is one always_ff for state and rp flags, one always_comb for grant and RAM muxing.
- The RAM instance remains outside the block, in the top level.

Test Plan:
- Solo CPU:
  - Stimulus: cpu write addr 0x10 data 0x5A, then cpu read 0x10.
  - Required: cpu_gnt on both cycles; ram_en = 1 only on the write; cpu_rvalid one cycle after the read with cpu_rdata = 0x5A; dbg_rvalid stays 0.
- Tie after reset:
  - Stimulus: both req held high with reads to 0x01 (cpu) and 0x02 (dbg), MAX_BURST = 4.
  - Required grant sequence: CPU x4, DBG x4, CPU x4.
- Burst reset on idle:
  - Stimulus: CPU granted 3 times, one cycle with no req, then both req.
  - Required: CPU granted 4 more times before DBG (cnt restarted from 0).
- Interleaved read return:
  - Stimulus: dbg reads 0x20 (holding 0x33) then cpu reads 0x21 (holding 0x44) in consecutive cycles.
  - Required: dbg_rvalid/dbg_rdata = 0x33, then cpu_rvalid/cpu_rdata = 0x44, in consecutive cycles; never both valid at once.
- Cross-port write then read:
  - Stimulus: dbg write 0x7F = 0xC3, then cpu read 0x7F on the next cycle.
  - Required: cpu_rdata = 0xC3 with cpu_rvalid.
- Reset mid-read:
  - Stimulus: cpu read granted in the same cycle rst is asserted.
  - Required: cpu_rvalid = 0 the following cycle; last = OWN_CPU and cnt = 0 after reset, so the next tie goes to the CPU.
